// File: rtl/dda_stepgen.sv
// dda_stepgen: multi-channel DDA step/direction generator with a double-buffered
// command per control period, magnitude clamping and a period-done handshake.
module dda_stepgen #(
    parameter int CH   = 4,
    parameter int NW   = 8,
    parameter int NMAX = 50,
    parameter int DIV  = 200
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr,
    input  logic [CH*(NW+1)-1:0]   n_in,
    output logic [CH-1:0]          pulse,
    output logic [CH-1:0]          dir,
    output logic                   busy,
    output logic                   ready,
    output logic                   period_done,
    output logic                   clamp
);
    localparam int AW = $clog2(2 * NMAX);
    localparam int SW = (NMAX > 1) ? $clog2(NMAX) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [AW-1:0] NM    = AW'(NMAX);
    localparam logic [AW-1:0] ACC0  = AW'(NMAX - 1);
    localparam logic [SW-1:0] SLAST = SW'(NMAX - 1);
    localparam logic [DW-1:0] DLAST = DW'(DIV - 1);

    logic [AW-1:0] mag    [CH];
    logic [AW-1:0] acc    [CH];
    logic [AW-1:0] sh_mag [CH];
    logic [AW-1:0] cm     [CH];
    logic [AW-1:0] sum    [CH];
    logic [CH-1:0] sh_dir, cd, hit;
    logic          sh_full, half, any_clamp, div_end, pe, load;
    logic [SW-1:0] slot;
    logic [DW-1:0] div;

    // Clamp incoming magnitudes and precompute each accumulator's slot update.
    always_comb begin
        any_clamp = 1'b0;
        for (int c = 0; c < CH; c++) begin
            cd[c]     = n_in[c*(NW+1)+NW];
            cm[c]     = (32'(n_in[c*(NW+1) +: NW]) > 32'(NMAX)) ? NM : AW'(n_in[c*(NW+1) +: NW]);
            any_clamp = any_clamp | (32'(n_in[c*(NW+1) +: NW]) > 32'(NMAX));
            sum[c]    = acc[c] + mag[c];
            hit[c]    = sum[c] >= NM;
        end
    end

    assign div_end = busy && div == DLAST;
    assign pe      = div_end && half && slot == SLAST;
    // A write landing on the period-end edge wins over a pending shadow.
    assign load    = (wr && (!busy || pe)) || (pe && sh_full);
    assign ready   = !sh_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse       <= '0;
            dir         <= '0;
            busy        <= 1'b0;
            sh_full     <= 1'b0;
            sh_dir      <= '0;
            half        <= 1'b0;
            slot        <= '0;
            div         <= '0;
            period_done <= 1'b0;
            clamp       <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                mag[c]    <= '0;
                acc[c]    <= '0;
                sh_mag[c] <= '0;
            end
        end else begin
            period_done <= pe;
            clamp       <= wr && any_clamp;
            if (wr && busy && !pe) begin
                sh_full <= 1'b1;
                sh_dir  <= cd;
                for (int c = 0; c < CH; c++) sh_mag[c] <= cm[c];
            end
            if (load) begin
                busy    <= 1'b1;
                sh_full <= 1'b0;
                dir     <= wr ? cd : sh_dir;
                half    <= 1'b0;
                slot    <= '0;
                div     <= '0;
                pulse   <= '0;
                for (int c = 0; c < CH; c++) begin
                    mag[c] <= wr ? cm[c] : sh_mag[c];
                    acc[c] <= ACC0;
                end
            end else if (pe) begin
                busy  <= 1'b0;
                half  <= 1'b0;
                slot  <= '0;
                div   <= '0;
                pulse <= '0;
            end else if (busy) begin
                div <= div_end ? '0 : div + 1'b1;
                if (div_end) begin
                    half <= !half;
                    if (half) begin
                        pulse <= '0;
                        slot  <= slot + 1'b1;
                    end else begin
                        pulse <= hit;
                        for (int c = 0; c < CH; c++) acc[c] <= hit[c] ? sum[c] - NM : sum[c];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_dda_stepgen.sv
// tb_dda_stepgen: directed test of dda_stepgen against a closed-form period model
// plus hand-computed pulse counts and timing points.
module tb_dda_stepgen;
    localparam int CH = 4, NW = 8, NMAX = 10, DIV = 4;
    localparam int P  = 2 * NMAX * DIV;

    logic                 clk = 1'b0, rst_n = 1'b1, wr = 1'b0;
    logic [CH*(NW+1)-1:0] n_in = '0;
    logic [CH-1:0]        pulse, dir;
    logic                 busy, ready, period_done, clamp;

    dda_stepgen #(.CH(CH), .NW(NW), .NMAX(NMAX), .DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .n_in(n_in), .pulse(pulse), .dir(dir),
        .busy(busy), .ready(ready), .period_done(period_done), .clamp(clamp)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [CH*(NW+1)-1:0] pk(input int m0, m1, m2, m3, input logic [3:0] d);
        int m[4];
        logic [CH*(NW+1)-1:0] v;
        m = '{m0, m1, m2, m3};
        v = '0;
        for (int c = 0; c < CH; c++) begin
            v[c*(NW+1) +: NW] = NW'(m[c]);
            v[c*(NW+1)+NW]    = d[c];
        end
        return v;
    endfunction

    function automatic int mg(input logic [CH*(NW+1)-1:0] v, input int c);
        int r;
        r = int'(v[c*(NW+1) +: NW]);
        return (r > NMAX) ? NMAX : r;
    endfunction

    // Pulses a channel of magnitude m has emitted by the end of slot k-1.
    function automatic int cnt(input int k, input int m);
        return (NMAX - 1 + k * m) / NMAX;
    endfunction

    // Model: period start cycle, active and shadow command, closed-form pulse position.
    int                   cyc = 0, m_start = 0, m_mag[CH];
    logic                 m_busy = 1'b0, m_sh = 1'b0;
    logic [CH*(NW+1)-1:0] m_sh_v = '0;
    logic [CH-1:0]        e_pulse = '0, e_dir = '0;
    logic                 e_pd = 1'b0, e_clamp = 1'b0;

    task automatic m_load(input logic [CH*(NW+1)-1:0] v);
        m_busy  = 1'b1;
        m_start = cyc;
        for (int c = 0; c < CH; c++) begin
            m_mag[c] = mg(v, c);
            e_dir[c] = v[c*(NW+1)+NW];
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_sh = 1'b0; e_pulse = '0; e_dir = '0; e_pd = 1'b0; e_clamp = 1'b0;
        end else begin
            int pos, s, r;
            logic at_end, cl;
            cyc++;
            at_end = m_busy && (cyc - m_start) == P;
            cl = 1'b0;
            for (int c = 0; c < CH; c++) cl = cl | (int'(n_in[c*(NW+1) +: NW]) > NMAX);
            e_pd    = at_end;
            e_clamp = wr && cl;
            if (wr && (!m_busy || at_end)) begin
                m_load(n_in); m_sh = 1'b0;
            end else if (at_end && m_sh) begin
                m_load(m_sh_v); m_sh = 1'b0;
            end else if (at_end) begin
                m_busy = 1'b0;
            end else if (m_busy && wr) begin
                m_sh_v = n_in; m_sh = 1'b1;
            end
            pos = cyc - m_start;
            s   = pos / (2 * DIV);
            r   = pos % (2 * DIV);
            for (int c = 0; c < CH; c++)
                e_pulse[c] = m_busy && pos < P && r >= DIV && cnt(s + 1, m_mag[c]) > cnt(s, m_mag[c]);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("pulse", int'(pulse), int'(e_pulse));
            chk("dir", int'(dir), int'(e_dir));
            chk("busy", int'(busy), int'(m_busy));
            chk("ready", int'(ready), int'(!m_sh));
            chk("period_done", int'(period_done), int'(e_pd));
            chk("clamp", int'(clamp), int'(e_clamp));
        end
    end

    // Per-run tallies for the hand-computed checks.
    int         rises[CH], busy_n, rdy_lo, pd_n, clamp_n, pd_at;
    logic       dir_h [256];
    logic       p_h   [256];
    logic [CH-1:0] prev_p;

    task automatic issue(input logic [CH*(NW+1)-1:0] v);
        @(negedge clk);
        n_in = v;
        wr   = 1'b1;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < CH; c++) rises[c] = 0;
        busy_n = 0; rdy_lo = 0; pd_n = 0; clamp_n = 0; pd_at = -1;
        prev_p = pulse;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            wr = 1'b0;
            for (int c = 0; c < CH; c++) if (pulse[c] && !prev_p[c]) rises[c]++;
            prev_p  = pulse;
            busy_n  += int'(busy);
            rdy_lo  += int'(!ready);
            pd_n    += int'(period_done);
            clamp_n += int'(clamp);
            if (period_done && pd_at < 0) pd_at = i - 1;
            if (i < 256) begin
                dir_h[i] = dir[0];
                p_h[i]   = pulse[0];
            end
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst pulse", int'(pulse), 0);
        chk("rst dir", int'(dir), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst ready", int'(ready), 1);
        chk("rst period_done", int'(period_done), 0);
        chk("rst clamp", int'(clamp), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        issue(pk(5, 0, 0, 0, 4'b0001));
        run(90);
        chk("t1 ch0 pulses", rises[0], 5);
        chk("t1 other pulses", rises[1] + rises[2] + rises[3], 0);
        chk("t1 busy clks", busy_n, 80);
        chk("t1 period_done clk", pd_at, 80);
        chk("t1 dir at wr", int'(dir_h[1]), 1);
        chk("t1 first pulse clk4", int'(p_h[4]), 0);
        chk("t1 first pulse clk5", int'(p_h[5]), 1);

        issue(pk(10, 1, 0, 3, 4'b0000));
        run(90);
        chk("t2 ch0", rises[0], 10);
        chk("t2 ch1", rises[1], 1);
        chk("t2 ch2", rises[2], 0);
        chk("t2 ch3", rises[3], 3);
        chk("t2 period_done", pd_n, 1);

        issue(pk(15, 0, 0, 0, 4'b0000));
        run(90);
        chk("t3 clamp pulses", clamp_n, 1);
        chk("t3 ch0", rises[0], 10);

        issue(pk(4, 0, 0, 0, 4'b0001));
        run(29);
        issue(pk(2, 0, 0, 0, 4'b0000));
        run(140);
        chk("t4 ready low clks", rdy_lo, 50);
        chk("t4 busy clks", busy_n, 130);
        chk("t4 ch0 pulses", rises[0], 4);
        chk("t4 dir before", int'(dir_h[50]), 1);
        chk("t4 dir after", int'(dir_h[51]), 0);
        chk("t4 B setup", int'(p_h[54]), 0);
        chk("t4 B first pulse", int'(p_h[55]), 1);
        chk("t4 period_done", pd_n, 2);

        issue(pk(1, 0, 0, 0, 4'b0000));
        run(10);
        issue(pk(3, 0, 0, 0, 4'b0000));
        run(10);
        issue(pk(7, 0, 0, 0, 4'b0000));
        run(160);
        chk("t5 ch0 pulses", rises[0], 7);

        issue(pk(5, 5, 5, 5, 4'b1111));
        run(9);
        issue(pk(6, 6, 6, 6, 4'b1111));
        run(29);
        @(negedge clk);
        chk("t6 busy pre-reset", int'(busy), 1);
        chk("t6 ready pre-reset", int'(ready), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 rst pulse", int'(pulse), 0);
        chk("t6 rst dir", int'(dir), 0);
        chk("t6 rst busy", int'(busy), 0);
        chk("t6 rst ready", int'(ready), 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        run(200);
        chk("t6 no pulses", rises[0] + rises[1] + rises[2] + rises[3], 0);
        chk("t6 no busy", busy_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dda_stepgen.md
# dda_stepgen

Parametrised multi-channel DDA step/direction pulse generator for the motion controller: converts one command per control period (per-channel step count plus direction) into evenly spread step pulses. Generalises the fixed 4-channel generator: channel count, magnitude width, steps-per-period and tick divider become parameters; it adds a synchronous command strobe, double-buffered commands for gap-free back-to-back periods, magnitude clamping and a period-done handshake.

## Interface
- `CH`, 4, number of axes/channels
- `NW`, 8, magnitude width per channel
- `NMAX`, 50, slots per control period (max pulses per period)
- `DIV`, 200, clk cycles per half-slot (20 MHz clk → 10 µs half-slot, 20 µs slot)
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `wr`  in  1  command strobe, one clk wide, sampled synchronously
- `n_in`  in  CH*(NW+1)  per channel c: bit c*(NW+1)+NW = direction, bits [c*(NW+1)+NW-1 : c*(NW+1)] = magnitude
- `pulse`  out  CH  step outputs
- `dir`  out  CH  direction outputs
- `busy`  out  1  a period is running
- `ready`  out  1  shadow buffer empty; new command will not overwrite a pending one
- `period_done`  out  1  one-clk pulse at every period end
- `clamp`  out  1  one-clk pulse when any loaded magnitude exceeded NMAX

## Operation
- Reset: pulse=0, dir=0, busy=0, ready=1, period_done=0, clamp=0; accumulators, counters, shadow cleared.
- Magnitude m > NMAX is clamped to NMAX at capture; clamp pulses the clk after the wr edge.
- Accumulator width AW = clog2(2*NMAX); acc < NMAX before add and m ≤ NMAX, so no overflow.
- Idle + wr: active regs load on that edge; busy←1, dir←command dir, acc←NMAX-1 (all channels), slot←0, half←0, divider←0.
- Each slot = two halves of DIV clks. First half: pulse=0 (direction setup). Entering second half: acc+=m; if acc≥NMAX then acc-=NMAX, pulse←1 for that half, else pulse←0.
- Initial acc=NMAX-1 ⇒ exactly m pulses per period, first in slot 0 when m≥1, spacing uniform within one slot.
- Busy + wr: command goes to shadow, ready←0. Second wr while shadow full overwrites shadow (last write wins).
- Period end (end of slot NMAX-1 second half): pulse←0, period_done pulses. Shadow full → shadow→active, dir update, acc reset, slot 0 starts on same edge, ready←1, busy stays 1. Shadow empty → busy←0; dir holds.
- wr coinciding with period-end edge while busy: treated as shadow write and promoted immediately (new period uses it).

## Timing
- Period = 2*NMAX*DIV clks exactly, back-to-back with no gap.
- First pulse rises DIV clks after wr edge; pulse width DIV clks; dir stable ≥ DIV clks before any rising pulse.
- busy falls 2*NMAX*DIV clks after the starting wr edge if no shadow.
- rst_n low mid-period: all outputs to reset values asynchronously; pending shadow discarded.
- m=0: no pulses, period still runs, busy/period_done behave normally.

## Test plan (NMAX=10, DIV=4, CH=4)
- wr ch0 m=5 dir=1, others 0 → ch0 5 pulses, each 4 clks, in slots 0,2,4,6,8; dir0=1 from wr edge; busy high 80 clks; period_done at clk 80.
- wr m={10,1,0,3} → ch0 pulses every slot (10), ch1 one in slot 0, ch2 none, ch3 three pulses; counts exact.
- wr m=15 → clamp pulses once; 10 pulses emitted.
- wr A (m=4), at clk 30 wr B (m=2, dir flipped) → ready low until clk 80; B starts seamlessly at clk 80, busy never drops; dir flips at clk 80, 4 clks before first B pulse.
- Two shadow writes during one period (m=3 then m=7) → next period emits 7.
- rst_n low at clk 40 mid-period with shadow full → pulse/dir/busy 0 immediately; after release no pulses until new wr.
